// File: rtl/fpu_pkg.sv
// Shared definitions for the CPU-bus-to-FPU sequencer: opcodes, register map,
// status/flag bit positions and controller states.
package fpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SQRT = 4'd4,
    OP_CMP  = 4'd5,
    OP_I2F  = 4'd6,
    OP_F2I  = 4'd7
  } fpu_op_e;

  localparam logic [3:0] ADDR_A0     = 4'd0;
  localparam logic [3:0] ADDR_B0     = 4'd4;
  localparam logic [3:0] ADDR_RES0   = 4'd8;
  localparam logic [3:0] ADDR_CMD    = 4'd12;
  localparam logic [3:0] ADDR_STATUS = 4'd13;
  localparam logic [3:0] ADDR_FLAGS  = 4'd14;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_CMD_ERR = 3;

  localparam int FL_INEXACT   = 0;
  localparam int FL_UNDERFLOW = 1;
  localparam int FL_OVERFLOW  = 2;
  localparam int FL_DIVZERO   = 3;
  localparam int FL_INVALID   = 4;

  localparam int CMD_IRQ_EN = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_sequencer.sv
// Byte-wide register front end that loads operands, launches the shared FPU
// datapath, waits for completion or timeout, and reports result/status/irq.
//
// state  | meaning
// IDLE   | accepting operand/command writes
// LAUNCH | fpu_start pulse, timeout counter cleared
// WAIT   | waiting for fpu_done or counter terminal count
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int FP_W    = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            cs,
  input  logic            wr,
  input  logic            rd,
  input  logic [3:0]      addr,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  output logic            irq,
  output logic            fpu_start,
  output logic [3:0]      fpu_op,
  output logic [FP_W-1:0] fpu_a,
  output logic [FP_W-1:0] fpu_b,
  input  logic            fpu_done,
  input  logic [FP_W-1:0] fpu_result,
  input  logic [4:0]      fpu_flags
);

  localparam int NBYTES = FP_W / 8;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FP_W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [4:0]       flags_q, flags_d;
  logic             done_q, done_d, tmo_q, tmo_d, err_q, err_d, irq_q, irq_d;

  logic wr_en, rd_en, busy, status_rd, guarded_addr;

  assign wr_en        = cs & wr;
  assign rd_en        = cs & rd;
  assign busy         = (state_q != IDLE);
  assign status_rd    = rd_en && (addr == ADDR_STATUS);
  assign guarded_addr = (addr < ADDR_RES0) || (addr == ADDR_CMD);

  assign fpu_start = (state_q == LAUNCH);
  assign fpu_op    = cmd_q[3:0];
  assign fpu_a     = a_q;
  assign fpu_b     = b_q;
  assign irq       = irq_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cmd_d   = cmd_q;
    flags_d = flags_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    err_d   = err_q;

    // Clear-on-read goes first so any set event below overrides it.
    if (status_rd) begin
      done_d = 1'b0;
      tmo_d  = 1'b0;
      err_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          for (int i = 0; i < NBYTES; i++) begin
            if (addr == 4'(int'(ADDR_A0) + i)) a_d[8*i +: 8] = din;
            if (addr == 4'(int'(ADDR_B0) + i)) b_d[8*i +: 8] = din;
          end
          if (addr == ADDR_CMD) begin
            cmd_d   = din;
            done_d  = 1'b0;
            tmo_d   = 1'b0;
            flags_d = '0;
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (fpu_done) begin
          res_d   = fpu_result;
          flags_d = fpu_flags;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (busy && wr_en && guarded_addr) err_d = 1'b1;

    irq_d = cmd_d[CMD_IRQ_EN] & (done_d | tmo_d);
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cmd_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cmd_q   <= cmd_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
    end
  end

  // Read mux works from registered values, so a same-cycle write reads old data.
  always_comb begin
    dout = 8'h00;
    if (rd_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (addr == 4'(int'(ADDR_A0) + i))   dout = a_q[8*i +: 8];
        if (addr == 4'(int'(ADDR_B0) + i))   dout = b_q[8*i +: 8];
        if (addr == 4'(int'(ADDR_RES0) + i)) dout = res_q[8*i +: 8];
      end
      if (addr == ADDR_CMD)    dout = cmd_q;
      if (addr == ADDR_STATUS) dout = {4'b0, err_q, tmo_q, done_q, busy};
      if (addr == ADDR_FLAGS)  dout = {3'b0, flags_q};
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer: directed scenarios plus randomized
// operand/command traffic against a register-map reference model.
module tb_fpu_sequencer;

  localparam int FP_W = 32;
  localparam int TMO  = 16;

  logic            clk;
  logic            arst;
  logic            cs, wr, rd;
  logic [3:0]      addr;
  logic [7:0]      din;
  logic [7:0]      dout;
  logic            irq;
  logic            fpu_start;
  logic [3:0]      fpu_op;
  logic [FP_W-1:0] fpu_a, fpu_b;
  logic            fpu_done;
  logic [FP_W-1:0] fpu_result;
  logic [4:0]      fpu_flags;

  fpu_sequencer #(.FP_W(FP_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .arst(arst), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
    .din(din), .dout(dout), .irq(irq), .fpu_start(fpu_start),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_done(fpu_done),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Datapath model: answers a start pulse after model_lat cycles when enabled;
  // the man_* signals let scenarios place a completion pulse by hand.
  bit              model_en  = 1'b0;
  int              model_lat = 3;
  logic [FP_W-1:0] model_res = '0;
  logic [4:0]      model_flags = '0;
  logic            mdl_done = 1'b0;
  logic [FP_W-1:0] mdl_res = '0;
  logic [4:0]      mdl_flags = '0;
  logic            man_done = 1'b0;
  logic [FP_W-1:0] man_res = '0;
  logic [4:0]      man_flags = '0;
  int              start_cnt = 0;

  assign fpu_done   = mdl_done | man_done;
  assign fpu_result = man_done ? man_res : mdl_res;
  assign fpu_flags  = man_done ? man_flags : mdl_flags;

  always @(negedge clk) if (fpu_start === 1'b1) start_cnt++;

  initial begin : fpu_model
    forever begin
      @(negedge clk);
      if (fpu_start === 1'b1 && model_en) begin
        repeat (model_lat) @(posedge clk);
        #1;
        mdl_res = model_res; mdl_flags = model_flags; mdl_done = 1'b1;
        @(posedge clk); #1;
        mdl_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  // Reference view of the register map.
  logic [7:0]      exp_a [4];
  logic [7:0]      exp_b [4];
  logic [FP_W-1:0] exp_res;
  logic [4:0]      exp_flags;
  logic [7:0]      exp_cmd;

  function automatic logic [7:0] exp_reg(input int a);
    if (a < 4)        return exp_a[a];
    else if (a < 8)   return exp_b[a-4];
    else if (a < 12)  return exp_res[8*(a-8) +: 8];
    else if (a == 12) return exp_cmd;
    else if (a == 14) return {3'b0, exp_flags};
    else              return 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin exp_a[i] = 8'h00; exp_b[i] = 8'h00; end
    exp_res = '0; exp_flags = '0; exp_cmd = 8'h00;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; din = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    #1 d = dout;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic bus_rw(input logic [3:0] a, input logic [7:0] d, output logic [7:0] q);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = a; din = d;
    #1 q = dout;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic write_word(input logic [3:0] base, input logic [31:0] w);
    for (int i = 0; i < 4; i++) bus_write(4'(int'(base) + i), w[8*i +: 8]);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    model_clear();
    @(negedge clk);
    total++; if (dout !== 8'h00) $display("FAIL reset_dout got %02h want 00", dout); else passed++;
    total++; if ({irq, fpu_start} !== 2'b00) $display("FAIL reset_irq_start got %b want 00", {irq, fpu_start}); else passed++;
    total++; if ({fpu_op, fpu_a, fpu_b} !== '0) $display("FAIL reset_fpu_bus got %h/%h/%h want 0", fpu_op, fpu_a, fpu_b); else passed++;
    bus_read(4'd13, d);
    total++; if (d !== 8'h00) $display("FAIL reset_status got %02h want 00", d); else passed++;
    bus_read(4'd12, d);
    total++; if (d !== 8'h00) $display("FAIL reset_cmd got %02h want 00", d); else passed++;
  endtask

  task automatic test_add();
    logic [7:0] d;
    model_en = 1'b1; model_lat = 3; model_res = 32'h4040_0000; model_flags = 5'b0;
    write_word(4'd0, 32'h3F80_0000);
    write_word(4'd4, 32'h4000_0000);
    bus_write(4'd12, 8'h80);
    repeat (10) @(posedge clk);
    total++; if (fpu_a !== 32'h3F80_0000) $display("FAIL add_fpu_a got %h want 3f800000", fpu_a); else passed++;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = 32'h4040_0000;
      bus_read(4'(8 + i), d);
      total++; if (d !== w[8*i +: 8]) $display("FAIL add_result_byte%0d got %02h want %02h", i, d, w[8*i +: 8]); else passed++;
    end
    total++; if (irq !== 1'b1) $display("FAIL add_irq_set got %b want 1", irq); else passed++;
    bus_read(4'd13, d);
    total++; if (d !== 8'h02) $display("FAIL add_status got %02h want 02", d); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL add_irq_cleared got %b want 0", irq); else passed++;
    bus_read(4'd13, d);
    total++; if (d !== 8'h00) $display("FAIL add_status_after_clear got %02h want 00", d); else passed++;
  endtask

  task automatic test_div();
    logic [7:0] d;
    logic [31:0] w;
    model_en = 1'b1; model_lat = 2; model_res = 32'h7F80_0000; model_flags = 5'b01000;
    write_word(4'd4, 32'h0000_0000);
    bus_write(4'd12, 8'h03);
    repeat (8) @(posedge clk);
    bus_read(4'd14, d);
    total++; if (d !== 8'h08) $display("FAIL div_flags got %02h want 08", d); else passed++;
    w = 32'h7F80_0000;
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(8 + i), d);
      total++; if (d !== w[8*i +: 8]) $display("FAIL div_result_byte%0d got %02h want %02h", i, d, w[8*i +: 8]); else passed++;
    end
    total++; if (irq !== 1'b0) $display("FAIL div_irq got %b want 0", irq); else passed++;
    bus_read(4'd13, d);
    total++; if (d !== 8'h02) $display("FAIL div_status got %02h want 02", d); else passed++;
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    int s0;
    logic [31:0] w;
    model_en = 1'b0;
    s0 = start_cnt;
    bus_write(4'd12, 8'h02);
    // now in the start cycle
    total++; if (fpu_start !== 1'b1) $display("FAIL tmo_start_pulse got %b want 1", fpu_start); else passed++;
    repeat (TMO) @(posedge clk);
    #1;
    bus_read(4'd13, d);
    total++; if (d !== 8'h01) $display("FAIL tmo_status_before got %02h want 01", d); else passed++;
    bus_read(4'd13, d);
    total++; if (d !== 8'h04) $display("FAIL tmo_status_at got %02h want 04", d); else passed++;
    total++; if (start_cnt - s0 !== 1) $display("FAIL tmo_start_count got %0d want 1", start_cnt - s0); else passed++;
    w = 32'h7F80_0000;
    bus_read(4'd11, d);
    total++; if (d !== w[31:24]) $display("FAIL tmo_result_kept got %02h want %02h", d, w[31:24]); else passed++;
    bus_read(4'd14, d);
    total++; if (d !== 8'h00) $display("FAIL tmo_flags_cleared got %02h want 00", d); else passed++;
  endtask

  task automatic test_busy_write();
    logic [7:0] d;
    int s0;
    model_en = 1'b1; model_lat = 6; model_res = 32'h1111_2222; model_flags = 5'b00001;
    write_word(4'd4, 32'h4000_0000);
    s0 = start_cnt;
    bus_write(4'd12, 8'h01);
    bus_write(4'd4, 8'hAA);
    bus_write(4'd12, 8'h07);
    total++; if (fpu_b !== 32'h4000_0000) $display("FAIL busy_fpu_b got %h want 40000000", fpu_b); else passed++;
    total++; if (fpu_op !== 4'h1) $display("FAIL busy_fpu_op got %h want 1", fpu_op); else passed++;
    repeat (20) @(posedge clk);
    total++; if (start_cnt - s0 !== 1) $display("FAIL busy_start_count got %0d want 1", start_cnt - s0); else passed++;
    bus_read(4'd13, d);
    total++; if (d !== 8'h0A) $display("FAIL busy_status got %02h want 0a", d); else passed++;
    bus_read(4'd12, d);
    total++; if (d !== 8'h01) $display("FAIL busy_cmd_readback got %02h want 01", d); else passed++;
  endtask

  task automatic test_same_cycle();
    logic [7:0] d;
    model_en = 1'b0;
    bus_write(4'd12, 8'h84);
    @(posedge clk); #1;
    @(negedge clk);
    man_res = 32'hCAFE_F00D; man_flags = 5'b00100; man_done = 1'b1;
    cs = 1'b1; rd = 1'b1; addr = 4'd13;
    #1 d = dout;
    @(posedge clk); #1;
    man_done = 1'b0; cs = 1'b0; rd = 1'b0;
    total++; if (d !== 8'h01) $display("FAIL same_cycle_status got %02h want 01", d); else passed++;
    total++; if (irq !== 1'b1) $display("FAIL same_cycle_irq got %b want 1", irq); else passed++;
    bus_read(4'd13, d);
    total++; if (d !== 8'h02) $display("FAIL same_cycle_done got %02h want 02", d); else passed++;
    bus_read(4'd9, d);
    total++; if (d !== 8'hF0) $display("FAIL same_cycle_result got %02h want f0", d); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    model_en = 1'b0;
    write_word(4'd0, 32'h1234_5678);
    bus_write(4'd12, 8'h85);
    repeat (3) @(posedge clk);
    @(negedge clk); arst = 1'b1;
    @(posedge clk); #1 arst = 1'b0;
    model_clear();
    @(negedge clk);
    man_res = 32'hDEAD_BEEF; man_flags = 5'h1F; man_done = 1'b1;
    @(posedge clk); #1 man_done = 1'b0;
    @(negedge clk);
    total++; if ({irq, fpu_start, dout} !== 10'b0) $display("FAIL rstmid_irq_start_dout got %b want 0", {irq, fpu_start, dout}); else passed++;
    total++; if ({fpu_op, fpu_a, fpu_b} !== '0) $display("FAIL rstmid_fpu_bus got %h/%h/%h want 0", fpu_op, fpu_a, fpu_b); else passed++;
    bus_read(4'd13, d);
    total++; if (d !== 8'h00) $display("FAIL rstmid_status got %02h want 00", d); else passed++;
    for (int a = 8; a < 15; a++) begin
      if (a == 13) continue;
      bus_read(4'(a), d);
      total++; if (d !== exp_reg(a)) $display("FAIL rstmid_reg%0d got %02h want %02h", a, d, exp_reg(a)); else passed++;
    end
  endtask

  task automatic test_random();
    logic [7:0] d, nb, cmd;
    int s0;
    for (int it = 0; it < 6; it++) begin
      nb = 8'($urandom);
      bus_rw(4'd0, nb, d);
      total++; if (d !== exp_a[0]) $display("FAIL rand%0d_rw_old got %02h want %02h", it, d, exp_a[0]); else passed++;
      exp_a[0] = nb;
      for (int i = 1; i < 4; i++) begin
        nb = 8'($urandom); bus_write(4'(i), nb); exp_a[i] = nb;
      end
      for (int i = 0; i < 4; i++) begin
        nb = 8'($urandom); bus_write(4'(4 + i), nb); exp_b[i] = nb;
      end
      cmd = 8'($urandom);
      model_en = 1'b1;
      model_lat = int'($urandom_range(1, 10));
      model_res = $urandom;
      model_flags = 5'($urandom);
      s0 = start_cnt;
      bus_write(4'd12, cmd);
      exp_cmd = cmd; exp_res = model_res; exp_flags = model_flags;
      repeat (14) @(posedge clk);
      #1;
      total++; if (start_cnt - s0 !== 1) $display("FAIL rand%0d_starts got %0d want 1", it, start_cnt - s0); else passed++;
      total++; if (fpu_op !== cmd[3:0]) $display("FAIL rand%0d_op got %h want %h", it, fpu_op, cmd[3:0]); else passed++;
      total++; if (fpu_a !== {exp_a[3], exp_a[2], exp_a[1], exp_a[0]}) $display("FAIL rand%0d_fpu_a got %h", it, fpu_a); else passed++;
      total++; if (fpu_b !== {exp_b[3], exp_b[2], exp_b[1], exp_b[0]}) $display("FAIL rand%0d_fpu_b got %h", it, fpu_b); else passed++;
      for (int a = 0; a < 16; a++) begin
        if (a == 13) continue;
        bus_read(4'(a), d);
        total++; if (d !== exp_reg(a)) $display("FAIL rand%0d_reg%0d got %02h want %02h", it, a, d, exp_reg(a)); else passed++;
      end
      total++; if (irq !== cmd[7]) $display("FAIL rand%0d_irq got %b want %b", it, irq, cmd[7]); else passed++;
      bus_read(4'd13, d);
      total++; if (d !== 8'h02) $display("FAIL rand%0d_status got %02h want 02", it, d); else passed++;
      total++; if (irq !== 1'b0) $display("FAIL rand%0d_irq_clear got %b want 0", it, irq); else passed++;
    end
  endtask

  initial begin
    arst = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 4'd0; din = 8'h00;
    test_reset();
    test_add();
    test_div();
    test_timeout();
    test_busy_write();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
